// File: rtl/gate_truth_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gtc_pkg
// Description : Shared types and constants for the gate truth checker.
//               Contains the checker state encoding, common 2-input and
//               1-input truth tables, and the vector-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gtc_pkg;

    // Checker sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } gtc_state_e;

    // Expected truth tables; bit k is the output for input vector k
    localparam logic [3:0] c_TRUTH_NAND2 = 4'b0111;
    localparam logic [3:0] c_TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] c_TRUTH_OR2   = 4'b1110;
    localparam logic [1:0] c_TRUTH_NOT   = 2'b01;

    // Number of input combinations for an n-input gate
    function automatic int num_vectors(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_truth_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_checker_if
// Description : Control, stimulus and result bundle between the checker and
//               the gate under test / lab top-level.
//               Optional macro GATE_TRUTH_CHECKER_FAILMAP_EN adds fail_map.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_truth_checker_if
    import gtc_pkg::*;
#(
    parameter int N_IN = 2
);
    logic              start;
    logic [N_IN-1:0]   stim;
    logic              resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail;
`ifdef GATE_TRUTH_CHECKER_FAILMAP_EN
    logic [num_vectors(N_IN)-1:0] fail_map;
`endif

    // Checker side
    modport master (
        input  start, resp,
        output stim, busy, done, pass, err_count, first_fail
`ifdef GATE_TRUTH_CHECKER_FAILMAP_EN
        , output fail_map
`endif
    );

    // Requester / gate-under-test side
    modport slave (
        output start, resp,
        input  stim, busy, done, pass, err_count, first_fail
`ifdef GATE_TRUTH_CHECKER_FAILMAP_EN
        , input fail_map
`endif
    );

endinterface
`default_nettype wire

// File: rtl/gate_truth_checker_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : gtc_settle_timer
// Description : 8-bit loadable down-counter that stops at zero and flags it.
//               Times the settle window after each stimulus vector.
// Revision    : 1.0 - initial release
// ============================================================================
module gtc_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_zero
);

    logic [7:0] r_count;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_checker
// Description : Sweeps every input vector onto a gate under test, samples the
//               response after a settle window and compares it against the
//               TRUTH table. Reports pass, mismatch count and first failure.
//               Optional macro GATE_TRUTH_CHECKER_FAILMAP_EN adds a per-vector
//               mismatch map.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_checker
    import gtc_pkg::*;
#(
    parameter int                         N_IN   = 2,
    parameter int                         SETTLE = 4,
    parameter logic [num_vectors(N_IN)-1:0] TRUTH  = 4'b0111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_truth_checker_if.master  bus
);

    localparam int              c_NUM_VEC     = num_vectors(N_IN);
    localparam int              c_ERR_W       = N_IN + 1;
    localparam logic [N_IN-1:0] c_LAST_VEC    = '1;
    localparam logic [7:0]      c_SETTLE_LOAD = 8'(SETTLE - 1);

    gtc_state_e            r_state,      w_state;
    logic [N_IN-1:0]       r_stim,       w_stim;
    logic                  r_busy,       w_busy;
    logic                  r_done,       w_done;
    logic                  r_pass,       w_pass;
    logic [c_ERR_W-1:0]    r_err_count,  w_err_count;
    logic [N_IN-1:0]       r_first_fail, w_first_fail;
    logic [c_NUM_VEC-1:0]  r_fail_map,   w_fail_map;
    logic                  w_timer_load;
    logic                  w_timer_zero;

    gtc_settle_timer u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (c_SETTLE_LOAD),
        .o_zero     (w_timer_zero)
    );

    // State and result registers; reset discards any partial sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_map   <= '0;
        end else begin
            r_state      <= w_state;
            r_stim       <= w_stim;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_pass       <= w_pass;
            r_err_count  <= w_err_count;
            r_first_fail <= w_first_fail;
            r_fail_map   <= w_fail_map;
        end
    end

    // Next-state and result update; final results are registered on the
    // SAMPLE->FINISH transition so they appear together with done
    always_comb begin
        w_state      = r_state;
        w_stim       = r_stim;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_pass       = r_pass;
        w_err_count  = r_err_count;
        w_first_fail = r_first_fail;
        w_fail_map   = r_fail_map;
        w_timer_load = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_err_count  = '0;
                    w_first_fail = '0;
                    w_fail_map   = '0;
                    w_stim       = '0;
                    w_busy       = 1'b1;
                    w_timer_load = 1'b1;
                    w_state      = DRIVE;
                end
            end
            DRIVE: begin
                if (w_timer_zero) begin
                    w_state = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bus.resp != TRUTH[r_stim]) begin
                    w_err_count = r_err_count + c_ERR_W'(1);
                    w_fail_map[r_stim] = 1'b1;
                    if (r_err_count == '0) begin
                        w_first_fail = r_stim;
                    end
                end
                if (r_stim == c_LAST_VEC) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_pass  = (w_err_count == '0);
                    w_state = FINISH;
                end else begin
                    w_stim       = r_stim + N_IN'(1);
                    w_timer_load = 1'b1;
                    w_state      = DRIVE;
                end
            end
            FINISH: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.stim       = r_stim;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.first_fail = r_first_fail;
`ifdef GATE_TRUTH_CHECKER_FAILMAP_EN
    assign bus.fail_map   = r_fail_map;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_checker
// Description : Directed self-checking bench for gate_truth_checker with a
//               2-input NAND configuration and a 1-input NOT configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_checker;

    logic clk = 1'b0;
    logic rst_n;
    int   mode;       // 0: NAND response, 1: AND response, 2: stuck at 1
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat, nd, sb;

    always #5 clk = ~clk;

    gate_truth_checker_if #(.N_IN(2)) bus_a ();
    gate_truth_checker_if #(.N_IN(1)) bus_b ();

    gate_truth_checker #(.N_IN(2), .SETTLE(4), .TRUTH(4'b0111)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    gate_truth_checker #(.N_IN(1), .SETTLE(4), .TRUTH(2'b01)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.resp = (mode == 0) ? ~(bus_a.stim[1] & bus_a.stim[0]) :
                        (mode == 1) ?  (bus_a.stim[1] & bus_a.stim[0]) : 1'b1;
    assign bus_b.resp = ~(bus_b.stim[0] & bus_b.stim[0]);

    task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    endtask

    // One sweep on DUT A; start rises just after a falling edge, and the
    // falling edge i cycles later is counted as latency i
    task automatic sweep_a(input int repulse, output int latency, output int n_done, output int stim_bad);
        latency  = 0;
        n_done   = 0;
        stim_bad = 0;
        bus_a.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            bus_a.start = (repulse != 0) && (i == 8 || i == 12);
            if (i <= 20 && int'(bus_a.stim) != (i - 1) / 5) stim_bad++;
            if (bus_a.done) begin
                n_done++;
                if (latency == 0) latency = i;
            end
            if (i == 10) chk("busy_mid", 32'(bus_a.busy), 32'd1);
            if (i == 21) chk("busy_finish", 32'(bus_a.busy), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stim",       32'(bus_a.stim),       32'd0);
        chk("rst_busy",       32'(bus_a.busy),       32'd0);
        chk("rst_done",       32'(bus_a.done),       32'd0);
        chk("rst_pass",       32'(bus_a.pass),       32'd0);
        chk("rst_err",        32'(bus_a.err_count),  32'd0);
        chk("rst_first_fail", 32'(bus_a.first_fail), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct NAND response
        mode = 0;
        sweep_a(0, lat, nd, sb);
        chk("nand_latency", 32'(lat), 32'd21);
        chk("nand_done_cnt", 32'(nd), 32'd1);
        chk("nand_stim_seq", 32'(sb), 32'd0);
        chk("nand_pass", 32'(bus_a.pass), 32'd1);
        chk("nand_err", 32'(bus_a.err_count), 32'd0);
        chk("nand_first_fail", 32'(bus_a.first_fail), 32'd0);

        // AND response: every vector mismatches
        mode = 1;
        sweep_a(0, lat, nd, sb);
        chk("and_latency", 32'(lat), 32'd21);
        chk("and_pass", 32'(bus_a.pass), 32'd0);
        chk("and_err", 32'(bus_a.err_count), 32'd4);
        chk("and_first_fail", 32'(bus_a.first_fail), 32'd0);
`ifdef GATE_TRUTH_CHECKER_FAILMAP_EN
        chk("and_fail_map", 32'(bus_a.fail_map), 32'hF);
`endif

        // Stuck at 1: only vector 3 mismatches
        mode = 2;
        sweep_a(0, lat, nd, sb);
        chk("stuck_pass", 32'(bus_a.pass), 32'd0);
        chk("stuck_err", 32'(bus_a.err_count), 32'd1);
        chk("stuck_first_fail", 32'(bus_a.first_fail), 32'd3);
`ifdef GATE_TRUTH_CHECKER_FAILMAP_EN
        chk("stuck_fail_map", 32'(bus_a.fail_map), 32'h8);
`endif

        // Start re-pulsed during a running sweep is ignored
        mode = 0;
        sweep_a(1, lat, nd, sb);
        chk("repulse_latency", 32'(lat), 32'd21);
        chk("repulse_done_cnt", 32'(nd), 32'd1);
        chk("repulse_stim_seq", 32'(sb), 32'd0);
        chk("repulse_pass", 32'(bus_a.pass), 32'd1);

        // Reset asserted while stim=2 discards the sweep
        bus_a.start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
        end
        chk("rst_mid_pre_stim", 32'(bus_a.stim), 32'd2);
        rst_n = 1'b0;
        nd = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus_a.done) nd++;
        end
        chk("rst_mid_stim", 32'(bus_a.stim), 32'd0);
        chk("rst_mid_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_mid_pass", 32'(bus_a.pass), 32'd0);
        chk("rst_mid_err", 32'(bus_a.err_count), 32'd0);
        chk("rst_mid_first_fail", 32'(bus_a.first_fail), 32'd0);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus_a.done) nd++;
        end
        chk("rst_mid_no_done", 32'(nd), 32'd0);
        sweep_a(0, lat, nd, sb);
        chk("post_rst_latency", 32'(lat), 32'd21);
        chk("post_rst_pass", 32'(bus_a.pass), 32'd1);
        chk("post_rst_stim_seq", 32'(sb), 32'd0);

        // 1-input NOT built from NAND(x,x)
        lat = 0;
        bus_b.start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.done && lat == 0) lat = i;
        end
        chk("not_latency", 32'(lat), 32'd11);
        chk("not_pass", 32'(bus_b.pass), 32'd1);
        chk("not_err", 32'(bus_b.err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
